// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around a combinational ALU. It holds an internal register file
// and runs one instruction at a time through IDLE -> READ -> EXEC -> WB.
module alu_issue_ctrl #(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 3,
    parameter int CTRL_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [CTRL_W-1:0]  instr_op,
    input  logic [RADDR_W-1:0] instr_rd,
    input  logic [RADDR_W-1:0] instr_rs,
    input  logic [RADDR_W-1:0] instr_rt,
    input  logic               instr_imm_en,
    input  logic [DATA_W-1:0]  instr_imm,
    output logic [DATA_W-1:0]  alu_ina,
    output logic [DATA_W-1:0]  alu_inb,
    output logic [CTRL_W-1:0]  alu_ctrl,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_zero,
    output logic               wb_valid,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               zero_flag,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int NREG = 2 ** RADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [CTRL_W-1:0]  op_q;
    logic [RADDR_W-1:0] rd_q, rs_q, rt_q;
    logic               imm_en_q;
    logic [DATA_W-1:0]  imm_q;
    logic [DATA_W-1:0]  op_a_q, op_b_q;
    logic [CTRL_W-1:0]  alu_ctrl_q;
    logic [DATA_W-1:0]  res_q;
    logic               zero_cap_q;
    logic               zero_flag_q;
    logic [DATA_W-1:0]  rf_q [NREG];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            alu_ctrl_q  <= '0;
            res_q       <= '0;
            zero_cap_q  <= 1'b0;
            zero_flag_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q     <= instr_op;
                        rd_q     <= instr_rd;
                        rs_q     <= instr_rs;
                        rt_q     <= instr_rt;
                        imm_en_q <= instr_imm_en;
                        imm_q    <= instr_imm;
                    end
                end
                // Operand regs double as the ALU drivers, so they only move entering EXEC.
                S_READ: begin
                    op_a_q     <= rf_q[rs_q];
                    op_b_q     <= imm_en_q ? imm_q : rf_q[rt_q];
                    alu_ctrl_q <= op_q;
                end
                S_EXEC: begin
                    res_q      <= alu_out;
                    zero_cap_q <= alu_zero;
                end
                S_WB: begin
                    // R0 is never written, so it keeps its reset value of zero.
                    if (rd_q != '0) begin
                        rf_q[rd_q] <= res_q;
                    end
                    zero_flag_q <= zero_cap_q;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_ina     = op_a_q;
    assign alu_inb     = op_b_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign wb_valid    = (state_q == S_WB);
    assign wb_rd       = rd_q;
    assign wb_data     = res_q;
    assign zero_flag   = zero_flag_q;
    assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: the bench plays the ALU and tracks the architectural
// register file. It runs directed scenarios followed by random instructions.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rd, instr_rs, instr_rt;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic [7:0] alu_ina, alu_inb;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       zero_flag;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(8), .RADDR_W(3), .CTRL_W(3)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .zero_flag(zero_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behaviour of the 8-bit ALU sitting behind the stage.
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return (a < b) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_ctrl, alu_ina, alu_inb);
    assign alu_zero = (alu_out == 8'd0);

    int checks   = 0;
    int failures = 0;

    logic [7:0] mr [8];
    logic       mzf;
    logic [7:0] last_a, last_b;
    logic [2:0] last_op;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mr[i] = 8'd0;
        mzf     = 1'b0;
        last_a  = 8'd0;
        last_b  = 8'd0;
        last_op = 3'd0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(instr_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic ie, input logic [7:0] imm);
        logic [7:0] a, b, r;
        wait_ready();
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        instr_imm_en = ie; instr_imm = imm; instr_valid = 1'b1;
        a = mr[rs];
        b = ie ? imm : mr[rt];
        r = alu_f(op, a, b);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("read_ready", 32'(instr_ready), 32'd0);
        check("read_wbv", 32'(wb_valid), 32'd0);
        check("read_hold_a", 32'(alu_ina), 32'(last_a));
        check("read_hold_ctrl", 32'(alu_ctrl), 32'(last_op));
        @(negedge clk);
        check("exec_ina", 32'(alu_ina), 32'(a));
        check("exec_inb", 32'(alu_inb), 32'(b));
        check("exec_ctrl", 32'(alu_ctrl), 32'(op));
        check("exec_wbv", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("wb_valid", 32'(wb_valid), 32'd1);
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("wb_data", 32'(wb_data), 32'(r));
        check("wb_zf_old", 32'(zero_flag), 32'(mzf));
        check("wb_hold_b", 32'(alu_inb), 32'(b));
        if (rd != 3'd0) mr[rd] = r;
        mzf = (r == 8'd0);
        last_a = a; last_b = b; last_op = op;
        @(negedge clk);
        check("post_ready", 32'(instr_ready), 32'd1);
        check("post_wbv", 32'(wb_valid), 32'd0);
        check("post_zf", 32'(zero_flag), 32'(mzf));
        dbg_addr = rd;
        #1;
        check("post_dbg", 32'(dbg_data), 32'(mr[rd]));
        $display("instr op=%b rd=%0d rs=%0d rt=%0d ie=%0d imm=%02h -> %02h zf=%0d",
                 op, rd, rs, rt, ie, imm, r, mzf);
    endtask

    task automatic dbg_expect(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops [5];
        int acc, wbn, last_acc;
        logic [7:0] chain [3];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;
        chain[0] = 8'h02; chain[1] = 8'h04; chain[2] = 8'h08;

        reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
        instr_rt = '0; instr_imm_en = 1'b0; instr_imm = '0; dbg_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        check("rst_zf", 32'(zero_flag), 32'd0);
        check("rst_ina", 32'(alu_ina), 32'd0);

        // Immediates and add
        issue(3'b001, 3'd1, 3'd0, 3'd0, 1'b1, 8'h23);
        issue(3'b001, 3'd2, 3'd0, 3'd0, 1'b1, 8'hFF);
        issue(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        check("add_wb", 32'(wb_data), 32'h22);
        check("add_zf", 32'(zero_flag), 32'd0);
        // Subtract and zero flag
        issue(3'b001, 3'd4, 3'd0, 3'd0, 1'b1, 8'h44);
        issue(3'b001, 3'd5, 3'd0, 3'd0, 1'b1, 8'h18);
        issue(3'b110, 3'd6, 3'd4, 3'd5, 1'b0, 8'h00);
        dbg_expect("sub_r6", 3'd6, 8'h2C);
        issue(3'b110, 3'd7, 3'd6, 3'd6, 1'b0, 8'h00);
        check("sub_zero_wb", 32'(wb_data), 32'h00);
        check("sub_zero_zf", 32'(zero_flag), 32'd1);
        // Logic ops with immediates
        issue(3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 8'hDF);
        dbg_expect("and_r2", 3'd2, 8'h03);
        issue(3'b001, 3'd3, 3'd1, 3'd0, 1'b1, 8'hFA);
        dbg_expect("or_r3", 3'd3, 8'hFB);
        // Write to R0 is dropped but still reported
        issue(3'b001, 3'd0, 3'd0, 3'd0, 1'b1, 8'h55);
        check("r0_wbdata", 32'(wb_data), 32'h55);
        dbg_expect("r0_dbg", 3'd0, 8'h00);

        // Reset while in EXEC
        wait_ready();
        instr_op = 3'b010; instr_rd = 3'd5; instr_rs = 3'd4; instr_rt = 3'd3;
        instr_imm_en = 1'b0; instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("mid_rst_ready", 32'(instr_ready), 32'd1);
        check("mid_rst_wbv", 32'(wb_valid), 32'd0);
        check("mid_rst_zf", 32'(zero_flag), 32'd0);
        check("mid_rst_ina", 32'(alu_ina), 32'd0);
        check("mid_rst_inb", 32'(alu_inb), 32'd0);
        check("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
        for (int i = 0; i < 8; i++) dbg_expect("mid_rst_dbg", 3'(i), 8'h00);
        @(negedge clk);
        check("mid_rst_nowb", 32'(wb_valid), 32'd0);

        // Reset coincident with a valid instruction
        reset = 1'b1; instr_valid = 1'b1;
        instr_op = 3'b001; instr_rd = 3'd1; instr_rs = 3'd0; instr_imm_en = 1'b1; instr_imm = 8'h77;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        check("rst_valid_ready", 32'(instr_ready), 32'd1);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_valid) acc++;
        end
        check("rst_valid_nowb", 32'(acc), 32'd0);
        dbg_expect("rst_valid_r1", 3'd1, 8'h00);

        // Continuous valid: dependent chain R1 = R1 + R1
        issue(3'b001, 3'd1, 3'd0, 3'd0, 1'b1, 8'h01);
        @(negedge clk);
        instr_op = 3'b010; instr_rd = 3'd1; instr_rs = 3'd1; instr_rt = 3'd1;
        instr_imm_en = 1'b0; instr_valid = 1'b1;
        acc = 0; wbn = 0; last_acc = -1;
        for (int i = 0; i < 12; i++) begin
            if (wb_valid) begin
                if (wbn < 3) check("hs_chain", 32'(wb_data), 32'(chain[wbn]));
                wbn++;
            end
            if (instr_ready) begin
                if (last_acc >= 0) check("hs_gap", 32'(i - last_acc), 32'd4);
                last_acc = i;
                acc++;
            end
            @(posedge clk); @(negedge clk);
        end
        instr_valid = 1'b0;
        check("hs_accepts", 32'(acc), 32'd3);
        check("hs_wbs", 32'(wbn), 32'd3);
        mr[1] = 8'h08; mzf = 1'b0; last_a = 8'h04; last_b = 8'h04; last_op = 3'b010;
        dbg_expect("hs_r1", 3'd1, 8'h08);
        $display("handshake accepts=%0d writebacks=%0d", acc, wbn);

        // Random instructions against the model
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 8; i++) dbg_expect("final_dbg", 3'(i), mr[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
